// File: rtl/unidade_controle_rodadas.sv
// Round controller for the memory game: plays the stored sequence, then checks the player's moves.
// Latency: jogar to first mostra_led in 2 edges; jogada to conta_E/conta_L in 3 edges.
// Backpressure: none; jogada is a one-cycle pulse consumed only in ESPERA, jogar only in INICIAL/terminal states.
module unidade_controle_rodadas #(
   parameter int ESTADO_W = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                jogar,
   input  logic                nivel,
   input  logic                fim_E,
   input  logic                fim_L_facil,
   input  logic                fim_L_dificil,
   input  logic                fim_T,
   input  logic                timeout,
   input  logic                jogada,
   input  logic                igual,
   output logic                zera_E,
   output logic                conta_E,
   output logic                zera_L,
   output logic                conta_L,
   output logic                zera_R,
   output logic                registra_R,
   output logic                zera_T,
   output logic                conta_T,
   output logic                mostra_led,
   output logic                pronto,
   output logic                ganhou,
   output logic                perdeu,
   output logic                db_timeout,
   output logic                nivel_reg,
   output logic [ESTADO_W-1:0] db_estado
);

   // State codes are exported on db_estado, so they are pinned explicitly.
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      MOSTRA      = 4'h2,
      PROX_MOSTRA = 4'h3,
      ESPERA      = 4'h4,
      REGISTRA    = 4'h5,
      COMPARA     = 4'h6,
      PROX_JOGADA = 4'h7,
      PROX_RODADA = 4'h8,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } estado_t;

   estado_t estado;
   estado_t proximo;
   logic    ultima;

   // Last round depends on the level latched at game start, not the live input.
   assign ultima = nivel_reg ? fim_L_dificil : fim_L_facil;

   // State register; reset wins over any pending transition.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= INICIAL;
      end else begin
         estado <= proximo;
      end
   end

   // Level is captured once per game so a mid-game change of nivel has no effect.
   always_ff @(posedge clock) begin
      if (reset) begin
         nivel_reg <= 1'b0;
      end else if (estado == PREPARA) begin
         nivel_reg <= nivel;
      end
   end

   // Next-state and control decode; every output defaults low.
   always_comb begin
      proximo    = estado;
      zera_E     = 1'b0;
      conta_E    = 1'b0;
      zera_L     = 1'b0;
      conta_L    = 1'b0;
      zera_R     = 1'b0;
      registra_R = 1'b0;
      zera_T     = 1'b0;
      conta_T    = 1'b0;
      mostra_led = 1'b0;
      pronto     = 1'b0;
      ganhou     = 1'b0;
      perdeu     = 1'b0;
      db_timeout = 1'b0;

      case (estado)
         INICIAL: begin
            if (jogar) begin
               proximo = PREPARA;
            end
         end

         PREPARA: begin
            zera_E  = 1'b1;
            zera_L  = 1'b1;
            zera_R  = 1'b1;
            zera_T  = 1'b1;
            proximo = MOSTRA;
         end

         MOSTRA: begin
            mostra_led = 1'b1;
            conta_T    = 1'b1;
            if (fim_T) begin
               proximo = PROX_MOSTRA;
            end
         end

         // The only state whose E control depends on an input: rewind E after
         // the last shown item so the move phase starts from item 0.
         PROX_MOSTRA: begin
            zera_T = 1'b1;
            if (fim_E) begin
               zera_E  = 1'b1;
               proximo = ESPERA;
            end else begin
               conta_E = 1'b1;
               proximo = MOSTRA;
            end
         end

         // A press in the same cycle as the timeout still counts as a move.
         ESPERA: begin
            conta_T = 1'b1;
            if (jogada) begin
               proximo = REGISTRA;
            end else if (timeout) begin
               proximo = FIM_TIMEOUT;
            end
         end

         REGISTRA: begin
            registra_R = 1'b1;
            zera_T     = 1'b1;
            proximo    = COMPARA;
         end

         COMPARA: begin
            if (!igual) begin
               proximo = FIM_ERRO;
            end else if (fim_E) begin
               proximo = ultima ? FIM_ACERTO : PROX_RODADA;
            end else begin
               proximo = PROX_JOGADA;
            end
         end

         PROX_JOGADA: begin
            conta_E = 1'b1;
            proximo = ESPERA;
         end

         PROX_RODADA: begin
            conta_L = 1'b1;
            zera_E  = 1'b1;
            zera_T  = 1'b1;
            proximo = MOSTRA;
         end

         FIM_ACERTO: begin
            pronto = 1'b1;
            ganhou = 1'b1;
            if (jogar) begin
               proximo = PREPARA;
            end
         end

         FIM_ERRO: begin
            pronto = 1'b1;
            perdeu = 1'b1;
            if (jogar) begin
               proximo = PREPARA;
            end
         end

         FIM_TIMEOUT: begin
            pronto     = 1'b1;
            perdeu     = 1'b1;
            db_timeout = 1'b1;
            if (jogar) begin
               proximo = PREPARA;
            end
         end

         default: begin
            proximo = INICIAL;
         end
      endcase
   end

   assign db_estado = ESTADO_W'(estado);

endmodule
